// File: rtl/mctrl_pkg.sv
// Shared types for the multi-cycle controller: state encoding,
// opcodes, ALU encodings and the decoded instruction-class bundle.
package mctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LW   = 3'b001;
    localparam logic [2:0] OP_SW   = 3'b010;
    localparam logic [2:0] OP_J    = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_ADDI = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef struct packed {
        logic is_alu;
        logic is_mem;
        logic is_load;
        logic is_jump;
        logic is_imm;
        logic is_sub;
        logic is_rsvd;
    } dec_t;

    // Where an instruction boundary goes: next fetch, or park in IDLE.
    function automatic state_t next_or_idle(input logic run);
        return run ? ST_FETCH : ST_IDLE;
    endfunction

endpackage

// File: rtl/mctrl_decode.sv
// Combinational opcode decode of ir[7:5] into instruction-class flags.
import mctrl_pkg::*;

module mctrl_decode (
    input  logic [2:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec = '0;
        unique case (opcode)
            OP_LW: begin
                dec.is_mem  = 1'b1;
                dec.is_load = 1'b1;
                dec.is_imm  = 1'b1;
            end
            OP_SW: begin
                dec.is_mem = 1'b1;
                dec.is_imm = 1'b1;
            end
            OP_J:    dec.is_jump = 1'b1;
            OP_ADD:  dec.is_alu  = 1'b1;
            OP_ADDI: begin
                dec.is_alu = 1'b1;
                dec.is_imm = 1'b1;
            end
            OP_SUB: begin
                dec.is_alu = 1'b1;
                dec.is_sub = 1'b1;
            end
            OP_RSVD: dec.is_rsvd = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mcycle_ctrl.sv
// Multi-cycle fetch/decode/execute controller with registered strobes.
// Build option MCTRL_HALT_EN: opcode 111 halts instead of trapping.
import mctrl_pkg::*;

module mcycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] ins_in,
    input  logic       mem_ack,
    output logic [7:0] pc,
    output logic [7:0] ir,
    output logic       alu_op,
    output logic       alu_src_imm,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       reg_we,
    output logic       wb_sel,
    output logic [2:0] state,
    output logic       halted,
    output logic       illegal
);

`ifdef MCTRL_HALT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    state_t state_q;
    state_t state_n;
    dec_t   dec;
    logic   ex_wb;

    mctrl_decode u_decode (
        .opcode (ir[7:5]),
        .dec    (dec)
    );

    always_comb begin
        state_n = ST_IDLE;
        unique case (state_q)
            ST_IDLE:   state_n = next_or_idle(run);
            ST_FETCH:  state_n = ST_DECODE;
            ST_DECODE: begin
                if (dec.is_rsvd && HALT_EN)
                    state_n = ST_HALT;
                else if (dec.is_alu || dec.is_mem)
                    state_n = ST_EXEC;
                else
                    state_n = next_or_idle(run);
            end
            ST_EXEC:   state_n = dec.is_mem ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (!mem_ack)
                    state_n = ST_MEM;
                else if (dec.is_load)
                    state_n = ST_WB;
                else
                    state_n = next_or_idle(run);
            end
            ST_WB:     state_n = next_or_idle(run);
            ST_HALT:   state_n = HALT_EN ? ST_HALT : ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    assign ex_wb = (state_n == ST_EXEC) || (state_n == ST_WB);

    // Strobes are computed from the next state so they are valid
    // for the whole cycle the FSM sits in the matching state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc          <= 8'd0;
            ir          <= 8'd0;
            alu_op      <= ALU_ADD;
            alu_src_imm <= 1'b0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            reg_we      <= 1'b0;
            wb_sel      <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            state_q <= state_n;
            if (state_q == ST_FETCH) begin
                ir <= ins_in;
                pc <= pc + 8'd1;
            end
            if (state_q == ST_DECODE && dec.is_jump)
                pc <= {3'b000, ir[4:0]};
            alu_op      <= (ex_wb && dec.is_sub) ? ALU_SUB : ALU_ADD;
            alu_src_imm <= ex_wb && dec.is_imm;
            mem_rd      <= (state_n == ST_MEM) && dec.is_load;
            mem_wr      <= (state_n == ST_MEM) && !dec.is_load;
            reg_we      <= state_n == ST_WB;
            wb_sel      <= (state_n == ST_WB) && dec.is_load;
            // ir is loaded on this same edge, so look at ins_in directly.
            illegal     <= !HALT_EN && (state_n == ST_DECODE)
                           && (ins_in[7:5] == OP_RSVD);
        end
    end

`ifdef MCTRL_HALT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            halted <= 1'b0;
        else
            halted <= state_n == ST_HALT;
    end
`else
    assign halted = 1'b0;
`endif

    assign state = state_q;

endmodule
